prog_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the cpu top.
- Receives a framed byte stream over a valid/ready interface and writes payload bytes into the 32x8 program memory.
- Holds the CPU in reset while loading, releases it only after a valid checksum, then watches `halt`.
- Frame format: length byte N (1..DEPTH), N payload bytes, one checksum byte.

---
 rtl/prog_loader.sv | 107 ++++++++++
 tb/tb_prog_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: accepts a framed byte stream (length, payload, checksum),
// writes the payload into program memory, then releases the CPU and waits for halt.
module prog_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          cpu_hold,
  input  logic          halt,
  output logic          done,
  output logic          err,
  output logic [AW:0]   bytes_loaded,
  output logic [2:0]    dbg_state
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready is a
  // registered state decode and never looks at in_valid, so a held byte simply waits.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RUN  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [AW:0]   len;
  logic [AW-1:0] cnt;
  logic [DW-1:0] sum;
  logic [DW-1:0] sum_chk;
  logic          accept;
  logic          last;
  logic          len_bad;

  assign accept    = in_valid && in_ready;
  assign last      = ({1'b0, cnt} == (len - (AW+1)'(1)));
  assign len_bad   = (in_data == '0) || (in_data > DW'(DEPTH));
  assign sum_chk   = sum + in_data;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start)  state_nxt = LEN;
      LEN:       if (accept) state_nxt = len_bad ? ERR : DATA;
      DATA:      if (accept && last) state_nxt = CSUM;
      CSUM:      if (accept) state_nxt = (sum_chk == '0) ? RUN : ERR;
      RUN:       if (halt)   state_nxt = DONE;
      DONE, ERR: if (start)  state_nxt = LEN;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      bytes_loaded <= '0;
      len          <= '0;
      cnt          <= '0;
      sum          <= '0;
    end else begin
      state    <= state_nxt;
      // Status outputs are decoded from the next state so they line up with it.
      in_ready <= (state_nxt == LEN) || (state_nxt == DATA) || (state_nxt == CSUM);
      cpu_hold <= (state_nxt != RUN);
      done     <= (state_nxt == DONE);
      err      <= (state_nxt == ERR);
      mem_wr   <= (state == DATA) && accept;

      if (state == LEN && accept && !len_bad) begin
        len          <= in_data[AW:0];
        cnt          <= '0;
        sum          <= in_data;
        bytes_loaded <= '0;
      end

      if (state == DATA && accept) begin
        mem_addr     <= cnt;
        mem_din      <= in_data;
        // Hold cnt on the final byte so it never runs past DEPTH-1.
        cnt          <= last ? cnt : cnt + AW'(1);
        bytes_loaded <= bytes_loaded + (AW+1)'(1);
        sum          <= sum_chk;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes are queued as bytes are driven
// and checked by a monitor as mem_wr pulses appear.
module tb_prog_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          cpu_hold;
  logic          halt;
  logic          done;
  logic          err;
  logic [AW:0]   bytes_loaded;
  logic [2:0]    dbg_state;

  logic [AW+DW-1:0] exp_q[$];
  int tests;
  int fails;
  int wr_count;

  prog_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .cpu_hold(cpu_hold), .halt(halt), .done(done), .err(err),
    .bytes_loaded(bytes_loaded), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      wr_count = wr_count + 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", {19'd0, mem_addr, mem_din}, 32'hFFFF_FFFF);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        chk("mem_write", {19'd0, mem_addr, mem_din}, {19'd0, e});
      end
    end
  end

  // Drivers
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte and hold it until accepted; leaves in_valid high for back-to-back use.
  task automatic send_byte(input logic [DW-1:0] b);
    int waited;
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) chk("accept_timeout", 32'(waited), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_payload(input logic [DW-1:0] b, input logic [AW-1:0] addr);
    exp_q.push_back({addr, b});
    send_byte(b);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    int waited;
    waited = 0;
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    while (done !== 1'b1 && waited < 20) begin
      waited++;
      @(posedge clk); #1;
    end
    chk("done_set", {31'd0, done}, 32'd1);
    chk("done_hold", {31'd0, cpu_hold}, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] s;
    logic [DW-1:0] b;
    int wr_before;

    tests = 0; fails = 0; wr_count = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; halt = 1'b0;

    // Asynchronous reset with random inputs, checked before any clock edge
    #2;
    start    = 1'($urandom_range(0, 1));
    in_valid = 1'($urandom_range(0, 1));
    in_data  = 8'($urandom_range(0, 255));
    halt     = 1'($urandom_range(0, 1));
    rst = 1'b0;
    #1;
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_bytes", {26'd0, bytes_loaded}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; halt = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // in_valid in IDLE is not consumed
    in_valid = 1'b1; in_data = 8'h05;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("idle_ready", {31'd0, in_ready}, 32'd0);
    chk("idle_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    chk("idle_no_wr", 32'(wr_count), 32'd0);
    in_valid = 1'b0;

    // Good frame, back-to-back
    pulse_start();
    chk("len_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h03);
    send_payload(8'hA1, 5'd0);
    send_payload(8'h22, 5'd1);
    send_payload(8'h63, 5'd2);
    chk("hold_before_csum", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'hD7);
    in_valid = 1'b0;
    chk("release_hold", {31'd0, cpu_hold}, 32'd0);
    chk("run_ready", {31'd0, in_ready}, 32'd0);
    chk("good_bytes", {26'd0, bytes_loaded}, 32'd3);
    idle_cycles(2);
    chk("good_wr_count", 32'(wr_count), 32'd3);
    chk("good_q_empty", 32'(exp_q.size()), 32'd0);
    wait_done();

    // Bad checksum
    pulse_start();
    chk("restart_done_clr", {31'd0, done}, 32'd0);
    chk("restart_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h03);
    send_payload(8'hA1, 5'd0);
    send_payload(8'h22, 5'd1);
    send_payload(8'h63, 5'd2);
    send_byte(8'h00);
    in_valid = 1'b0;
    chk("badsum_err", {31'd0, err}, 32'd1);
    chk("badsum_hold", {31'd0, cpu_hold}, 32'd1);
    chk("badsum_ready", {31'd0, in_ready}, 32'd0);
    idle_cycles(2);
    pulse_start();
    chk("err_clr", {31'd0, err}, 32'd0);
    chk("err_restart_ready", {31'd0, in_ready}, 32'd1);

    // Length bounds: 0 and DEPTH+1 rejected without writes
    wr_before = wr_count;
    send_byte(8'h00);
    in_valid = 1'b0;
    chk("len0_err", {31'd0, err}, 32'd1);
    idle_cycles(2);
    pulse_start();
    send_byte(8'h21);
    in_valid = 1'b0;
    chk("len33_err", {31'd0, err}, 32'd1);
    idle_cycles(2);
    chk("len_bad_no_wr", 32'(wr_count - wr_before), 32'd0);

    // Full-depth frame with gaps and a stray start mid-payload
    pulse_start();
    wr_before = wr_count;
    s = 8'h20;
    send_byte(8'h20);
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      s = s + b;
      send_payload(b, AW'(i));
      if (i == 10) begin
        in_valid = 1'b0;
        pulse_start();
      end else if ($urandom_range(0, 3) == 0) begin
        idle_cycles($urandom_range(1, 2));
      end
    end
    send_byte(8'(8'h00 - s));
    in_valid = 1'b0;
    chk("full_bytes", {26'd0, bytes_loaded}, 32'd32);
    chk("full_state", {29'd0, dbg_state}, {29'd0, S_RUN});
    chk("full_hold", {31'd0, cpu_hold}, 32'd0);
    idle_cycles(2);
    chk("full_wr_count", 32'(wr_count - wr_before), 32'd32);
    chk("full_q_empty", 32'(exp_q.size()), 32'd0);
    wait_done();

    // Reset after two of three payload bytes
    pulse_start();
    wr_before = wr_count;
    send_byte(8'h03);
    send_payload(8'h11, 5'd0);
    send_payload(8'h42, 5'd1);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("mid_rst_wr", {31'd0, mem_wr}, 32'd0);
    chk("mid_rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(3);
    chk("mid_rst_wr_count", 32'(wr_count - wr_before), 32'd2);
    chk("mid_rst_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
